veripac9_runctl: RTL and testbench
==================================

Name: veripac9_runctl

Overview:
Run/step sequencer for the veripac9 core, mapped into the ZX-Uno register space. Replaces host-toggled step/reset bits with a hardware scheduler. The host can issue a single step, run N steps, or free-run at a selectable rate, with a PC breakpoint and halt detection. Sits beside the veripac9 host wrapper and drives the core's step and reset inputs.

Parameters:
ZXUNO_CTRL_REG, 8'hFC, control (write) / status (read) register address
ZXUNO_COUNT_REG, 8'hFD, step-count register address
ZXUNO_BRK_REG, 8'hFE, breakpoint PC register address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
zxuno_addr  in  8  ZX-Uno register address
zxuno_regrd  in  1  register read strobe
zxuno_regwr  in  1  register write strobe, sampled at posedge clk
din  in  8  write data
dout  out  8  read data (combinational); 8'hZZ when not selected
oe_n  out  1  active-low read enable; 0 only while one of the three registers is read
cpu_pc  in  8  current core PC
cpu_halt  in  1  core halted flag
step  out  1  one-cycle step pulse to the core
cpu_reset  out  1  reset level to the core
busy  out  1  high while in RUN or STEP

Behaviour:
- Reset values: step=0, cpu_reset=0, busy=0, count=0, brk=0, brk_en=0, rate=0, brk_hit=0, halt_hit=0, state=IDLE, gap counter=0.
- CTRL write bits: [0] STEP cmd, [1] RUN cmd, [2] STOP cmd, [3] cpu_reset level, [4] brk_en, [7:5] rate. Bits 0-2 are self-clearing commands. Bits 3-7 are stored on every CTRL write.
- CTRL read bits: [0] busy, [1] brk_hit, [2] halt_hit, [3] cpu_reset, [4] brk_en, [7:5] rate.
- COUNT: write loads the 8-bit count; the write is ignored while busy. Read returns the live count.
- BRK: read/write, 8-bit breakpoint PC.
- States: IDLE, STEP, RUN.
  - IDLE -> STEP on a STEP cmd.
  - IDLE -> RUN on a RUN cmd.
  - Any -> IDLE on STOP, or on cpu_reset=1.
  - STEP -> IDLE after its single pulse.
- Command priority within one write: cpu_reset=1 > STOP > RUN > STEP. STEP/RUN received while busy are ignored.
- A STEP or RUN cmd clears brk_hit and halt_hit.
- While cpu_reset=1: no pulses, state held IDLE.
- Timing: a command written at edge N enters STEP/RUN at edge N. The first step pulse is high during cycle N+1 (edge N+1 to N+2), provided cpu_halt=0.
- Pulse period in RUN = 2*4^rate cycles (rate 0 -> 2, rate 7 -> 32768), measured rising edge to rising edge. Uses a 15-bit gap counter loaded with period-1 at each pulse; the next pulse is issued when it reaches 0.
- STEP issues exactly one pulse and does not modify count.
- Count in RUN:
  - If count was 0 at RUN start, run is unlimited and count stays 0.
  - Otherwise count decrements with each pulse. The pulse that decrements 1->0 is the last; state returns to IDLE in the following cycle.
- Pre-pulse checks (every pulse decision in STEP/RUN):
  - cpu_halt=1 -> no pulse, IDLE, halt_hit=1.
  - brk_en=1 and cpu_pc==brk and this is not the first pulse since the command -> no pulse, IDLE, brk_hit=1. The first-pulse exemption lets a run resume from the breakpoint address.
- STOP arriving in the same cycle a pulse is high: that pulse completes and no further pulses follow. STOP in IDLE is a no-op.
- Async reset mid-run: step drops to 0 immediately, all state returns to reset values.
- busy = (state != IDLE).

Test Plan:
- Reset, then read 0xFC/0xFD/0xFE -> 8'h00 each with oe_n=0; read any other address -> oe_n=1, dout=Z.
- Write COUNT=3, then CTRL=8'h02 (RUN, rate 0) -> exactly 3 one-cycle pulses, 2 cycles apart; busy falls the cycle after the 3rd pulse; COUNT reads 0.
- Write CTRL=8'h22 (rate 1) with COUNT=0 -> pulses every 8 cycles indefinitely; CTRL=8'h04 -> no further pulses, busy=0, COUNT still 0.
- Write BRK=8'h10, CTRL=8'h12 (RUN+brk_en), core PC reaches 8'h10 -> no pulse issued at 8'h10, status=8'h12 (brk_hit, brk_en). Re-issue RUN -> first pulse issued despite PC==8'h10.
- cpu_halt=1 while running -> pulses stop, status bit2=1. CTRL=8'h01 with cpu_halt still 1 -> no pulse, halt_hit set again.
- CTRL=8'h08 mid-run -> cpu_reset=1, busy=0 next cycle; then CTRL=8'h03 (STEP+RUN) with reset cleared -> RUN wins; async reset mid-run -> step=0 immediately.

Source files
------------

// File: rtl/veripac9_runctl.sv
// Run/step sequencer for the veripac9 core: host register block plus a scheduler
// that issues single steps, counted runs or free runs with breakpoint and halt stops.
module veripac9_runctl #(
    parameter logic [7:0] ZXUNO_CTRL_REG  = 8'hFC,
    parameter logic [7:0] ZXUNO_COUNT_REG = 8'hFD,
    parameter logic [7:0] ZXUNO_BRK_REG   = 8'hFE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    input  logic [7:0] cpu_pc,
    input  logic       cpu_halt,
    output logic       step,
    output logic       cpu_reset,
    output logic       busy
);

    // state  | meaning
    // S_IDLE | no scheduling, step held low
    // S_STEP | issue one pulse, then back to idle
    // S_RUN  | pulse every 2*4^rate cycles until count, stop, halt or breakpoint
    typedef enum logic [1:0] {S_IDLE, S_STEP, S_RUN} state_t;

    state_t      r_state, w_state_nx;
    logic        r_step, w_step_nx;
    logic [14:0] r_gap, w_gap_nx;
    logic [7:0]  r_count, w_count_nx;
    logic        r_brk_hit, w_brk_hit_nx;
    logic        r_halt_hit, w_halt_hit_nx;
    logic        r_first, w_first_nx;
    logic        r_unlim, w_unlim_nx;
    logic        r_cpu_reset, r_brk_en;
    logic [2:0]  r_rate;
    logic [7:0]  r_brk;

    logic        w_wr_ctrl, w_wr_count, w_wr_brk;
    logic        w_sel_ctrl, w_sel_count, w_sel_brk, w_rd;
    logic [7:0]  w_rdata;
    logic [14:0] w_gap_load;

    assign w_wr_ctrl  = zxuno_regwr && (zxuno_addr == ZXUNO_CTRL_REG);
    assign w_wr_count = zxuno_regwr && (zxuno_addr == ZXUNO_COUNT_REG);
    assign w_wr_brk   = zxuno_regwr && (zxuno_addr == ZXUNO_BRK_REG);

    // period-1 = 2*4^rate-1, i.e. the low 2*rate+1 bits set
    assign w_gap_load = 15'h7FFF >> (4'd14 - {r_rate, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_reset <= 1'b0;
            r_brk_en    <= 1'b0;
            r_rate      <= 3'd0;
            r_brk       <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_cpu_reset <= din[3];
                r_brk_en    <= din[4];
                r_rate      <= din[7:5];
            end
            if (w_wr_brk) r_brk <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= 1'b0;
            r_gap      <= 15'd0;
            r_count    <= 8'h00;
            r_brk_hit  <= 1'b0;
            r_halt_hit <= 1'b0;
            r_first    <= 1'b0;
            r_unlim    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_step     <= w_step_nx;
            r_gap      <= w_gap_nx;
            r_count    <= w_count_nx;
            r_brk_hit  <= w_brk_hit_nx;
            r_halt_hit <= w_halt_hit_nx;
            r_first    <= w_first_nx;
            r_unlim    <= w_unlim_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_step_nx     = 1'b0;
        w_gap_nx      = r_gap;
        w_count_nx    = r_count;
        w_brk_hit_nx  = r_brk_hit;
        w_halt_hit_nx = r_halt_hit;
        w_first_nx    = r_first;
        w_unlim_nx    = r_unlim;

        if (w_wr_count && r_state == S_IDLE) w_count_nx = din;

        if (w_wr_ctrl && (din[3] || din[2])) begin
            w_state_nx = S_IDLE;
        end else if (w_wr_ctrl && r_state == S_IDLE && (din[1] || din[0])) begin
            w_state_nx    = din[1] ? S_RUN : S_STEP;
            w_gap_nx      = 15'd0;
            w_first_nx    = 1'b1;
            w_unlim_nx    = (r_count == 8'h00);
            w_brk_hit_nx  = 1'b0;
            w_halt_hit_nx = 1'b0;
        end else if (r_state != S_IDLE) begin
            // the cycle after the final pulse returns to idle
            if (r_step && (r_state == S_STEP || (!r_unlim && r_count == 8'h00))) begin
                w_state_nx = S_IDLE;
            end else if (r_gap != 15'd0) begin
                w_gap_nx = r_gap - 15'd1;
            end else if (cpu_halt) begin
                w_state_nx    = S_IDLE;
                w_halt_hit_nx = 1'b1;
            end else if (r_brk_en && cpu_pc == r_brk && !r_first) begin
                w_state_nx   = S_IDLE;
                w_brk_hit_nx = 1'b1;
            end else begin
                w_step_nx  = 1'b1;
                w_gap_nx   = w_gap_load;
                w_first_nx = 1'b0;
                if (r_state == S_RUN && !r_unlim) w_count_nx = r_count - 8'd1;
            end
        end
    end

    assign step      = r_step;
    assign cpu_reset = r_cpu_reset;
    assign busy      = (r_state != S_IDLE);

    assign w_sel_ctrl  = (zxuno_addr == ZXUNO_CTRL_REG);
    assign w_sel_count = (zxuno_addr == ZXUNO_COUNT_REG);
    assign w_sel_brk   = (zxuno_addr == ZXUNO_BRK_REG);
    assign w_rd        = zxuno_regrd && (w_sel_ctrl || w_sel_count || w_sel_brk);

    always_comb begin
        w_rdata = 8'h00;
        if (w_sel_ctrl)
            w_rdata = {r_rate, r_brk_en, r_cpu_reset, r_halt_hit, r_brk_hit, busy};
        else if (w_sel_count)
            w_rdata = r_count;
        else if (w_sel_brk)
            w_rdata = r_brk;
    end

    assign dout = w_rd ? w_rdata : 8'hZZ;
    assign oe_n = !w_rd;

endmodule

// File: tb/tb_veripac9_runctl.sv
// Directed bench for veripac9_runctl: register access, counted/free runs, STOP,
// breakpoint resume, halt stop, core reset priority and async reset.
module tb_veripac9_runctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;
    logic [7:0] cpu_pc;
    logic       cpu_halt;
    logic       step;
    logic       cpu_reset;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulse_total = 0;
    int last_pulse_cyc = 0;
    int gap_last = 0;
    int base;
    logic [7:0] rd_d;
    logic       rd_oe;

    veripac9_runctl dut (
        .clk(clk), .reset(reset), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
        .cpu_pc(cpu_pc), .cpu_halt(cpu_halt), .step(step), .cpu_reset(cpu_reset),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // step high samples mid-cycle; gap is between the two latest pulses
    always @(negedge clk) begin
        if (step) begin
            gap_last       = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            pulse_total    = pulse_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        zxuno_addr  = a;
        din         = d;
        zxuno_regwr = 1'b1;
        @(posedge clk);
        #1;
        zxuno_regwr = 1'b0;
        zxuno_addr  = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic oen);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        #1;
        d           = dout;
        oen         = oe_n;
        zxuno_regrd = 1'b0;
        zxuno_addr  = 8'h00;
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
        din = 8'h00; cpu_pc = 8'h00; cpu_halt = 1'b0;
        cyc_wait(3);
        chk("rst_step", step, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cpu_reset", cpu_reset, 1'b0);
        @(negedge clk); reset = 1'b0;
        cyc_wait(1);

        rd(8'hFC, rd_d, rd_oe); chk("rst_ctrl", rd_d, 8'h00); chk("rst_ctrl_oe", rd_oe, 1'b0);
        rd(8'hFD, rd_d, rd_oe); chk("rst_count", rd_d, 8'h00); chk("rst_count_oe", rd_oe, 1'b0);
        rd(8'hFE, rd_d, rd_oe); chk("rst_brk", rd_d, 8'h00); chk("rst_brk_oe", rd_oe, 1'b0);
        rd(8'h10, rd_d, rd_oe); chk("unmapped_oe", rd_oe, 1'b1);

        // counted run of 3 at rate 0
        wr(8'hFD, 8'h03);
        rd(8'hFD, rd_d, rd_oe); chk("count_load", rd_d, 8'h03);
        base = pulse_total;
        wr(8'hFC, 8'h02);
        chk("run3_no_pulse_at_cmd", step, 1'b0);
        cyc_wait(1);
        chk("run3_first_pulse", step, 1'b1);
        chk("run3_busy", busy, 1'b1);
        cyc_wait(4);
        chk("run3_third_pulse", step, 1'b1);
        chk("run3_busy_last", busy, 1'b1);
        cyc_wait(1);
        chk("run3_busy_fall", busy, 1'b0);
        chk("run3_step_low", step, 1'b0);
        chk("run3_pulses", pulse_total - base, 3);
        chk("run3_period", gap_last, 2);
        rd(8'hFD, rd_d, rd_oe); chk("run3_count_end", rd_d, 8'h00);

        // unlimited run at rate 1, count write ignored while busy, then STOP
        base = pulse_total;
        wr(8'hFC, 8'h22);
        cyc_wait(40);
        chk("free_pulses", pulse_total - base, 5);
        chk("free_period", gap_last, 8);
        chk("free_busy", busy, 1'b1);
        wr(8'hFD, 8'h09);
        wr(8'hFC, 8'h04);
        base = pulse_total;
        cyc_wait(20);
        chk("stop_pulses", pulse_total - base, 0);
        chk("stop_busy", busy, 1'b0);
        rd(8'hFD, rd_d, rd_oe); chk("stop_count", rd_d, 8'h00);

        // breakpoint stop, then resume from the breakpoint address
        cpu_pc = 8'h0E;
        wr(8'hFE, 8'h10);
        rd(8'hFE, rd_d, rd_oe); chk("brk_reg", rd_d, 8'h10);
        base = pulse_total;
        wr(8'hFC, 8'h12);
        cyc_wait(1);
        chk("brk_first_pulse", step, 1'b1);
        cpu_pc = 8'h10;
        cyc_wait(3);
        chk("brk_busy", busy, 1'b0);
        chk("brk_pulses", pulse_total - base, 1);
        rd(8'hFC, rd_d, rd_oe); chk("brk_status", rd_d, 8'h12);
        base = pulse_total;
        wr(8'hFC, 8'h12);
        rd(8'hFC, rd_d, rd_oe); chk("resume_status", rd_d, 8'h11);
        cyc_wait(1);
        chk("resume_pulse", step, 1'b1);
        cyc_wait(3);
        chk("resume_busy", busy, 1'b0);
        chk("resume_pulses", pulse_total - base, 1);

        // halt stops a run; STEP while halted issues nothing
        cpu_pc = 8'h00;
        base = pulse_total;
        wr(8'hFC, 8'h02);
        cyc_wait(4);
        cpu_halt = 1'b1;
        cyc_wait(2);
        chk("halt_busy", busy, 1'b0);
        chk("halt_pulses", pulse_total - base, 2);
        rd(8'hFC, rd_d, rd_oe); chk("halt_status", rd_d, 8'h04);
        base = pulse_total;
        wr(8'hFC, 8'h01);
        rd(8'hFC, rd_d, rd_oe); chk("halt_step_clear", rd_d, 8'h01);
        cyc_wait(2);
        chk("halt_step_pulses", pulse_total - base, 0);
        chk("halt_step_busy", busy, 1'b0);
        rd(8'hFC, rd_d, rd_oe); chk("halt_step_status", rd_d, 8'h04);
        cpu_halt = 1'b0;

        // single step leaves the count alone
        wr(8'hFD, 8'h04);
        base = pulse_total;
        wr(8'hFC, 8'h01);
        cyc_wait(3);
        chk("step_pulses", pulse_total - base, 1);
        chk("step_busy", busy, 1'b0);
        rd(8'hFD, rd_d, rd_oe); chk("step_count", rd_d, 8'h04);

        // core reset mid-run, then STEP+RUN together, then async reset
        wr(8'hFD, 8'h00);
        wr(8'hFC, 8'h02);
        cyc_wait(2);
        wr(8'hFC, 8'h08);
        chk("creset_level", cpu_reset, 1'b1);
        chk("creset_busy", busy, 1'b0);
        base = pulse_total;
        cyc_wait(6);
        chk("creset_pulses", pulse_total - base, 0);
        rd(8'hFC, rd_d, rd_oe); chk("creset_status", rd_d, 8'h08);
        base = pulse_total;
        wr(8'hFC, 8'h03);
        chk("prio_cpu_reset", cpu_reset, 1'b0);
        chk("prio_busy", busy, 1'b1);
        cyc_wait(5);
        chk("prio_run_pulses", pulse_total - base, 2);
        chk("prio_run_busy", busy, 1'b1);
        chk("prio_step_high", step, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_step", step, 1'b0);
        chk("areset_busy", busy, 1'b0);
        @(negedge clk); reset = 1'b0;
        cyc_wait(1);
        rd(8'hFC, rd_d, rd_oe); chk("areset_ctrl", rd_d, 8'h00);
        rd(8'hFE, rd_d, rd_oe); chk("areset_brk", rd_d, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
